counter_sched: RTL and testbench

- Two-requester round-robin scheduler that owns one 4-bit counter slice (enable/mode/D in, Q out).
- Accepts commands over a valid/ready handshake: optional preload, then N steps of up-by-1, down-by-1 or down-by-3.
- Drives the counter's control pins cycle by cycle, counts wrap events, and returns the final Q and wrap count tagged with the requester id.
- Sits between the test/host logic and the counter slice of the 32-bit counter assembly.

---
 rtl/counter_sched_pkg.sv | 30 +++
 rtl/counter_sched_rr_arb2.sv | 23 ++
 rtl/counter_sched.sv | 162 ++++++++++++++++
 tb/tb_counter_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter slice scheduler: counter mode codes,
// scheduler state encoding and the wrap-detection rule.
package counter_sched_pkg;

  localparam logic [1:0] MODE_UP1  = 2'd0;
  localparam logic [1:0] MODE_DN1  = 2'd1;
  localparam logic [1:0] MODE_DN3  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_CAPT = 2'd3
  } state_e;

  // A step wraps when the pre-update Q is about to roll past 15 or below 0.
  function automatic logic wrap_hit(input logic [1:0] mode, input logic [3:0] q);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_UP1: hit = (q == 4'd15);
      MODE_DN1: hit = (q == 4'd0);
      MODE_DN3: hit = (q <= 4'd2);
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester
// that was not granted last.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (valid0_i && valid1_i) begin
      gnt0_o = last_grant_i;
      gnt1_o = !last_grant_i;
    end else begin
      gnt0_o = valid0_i;
      gnt1_o = valid1_i;
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler that sequences one 4-bit counter slice through
// preload/step commands and reports the final Q and wrap count per requester.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int STEPS_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_mode,
  input  logic               req0_preload,
  input  logic [3:0]         req0_d,
  input  logic [STEPS_W-1:0] req0_steps,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_mode,
  input  logic               req1_preload,
  input  logic [3:0]         req1_d,
  input  logic [STEPS_W-1:0] req1_steps,
  output logic               cnt_enable,
  output logic [1:0]         cnt_mode,
  output logic [3:0]         cnt_d,
  input  logic [3:0]         cnt_q,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [3:0]         result,
  output logic [STEPS_W-1:0] wraps
);

  function automatic logic [STEPS_W-1:0] sat_inc(input logic [STEPS_W-1:0] v);
    return (v == {STEPS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         d_q, d_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [STEPS_W-1:0] wcnt_q, wcnt_d;
  logic               id_q, id_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [3:0]         result_q, result_d;
  logic [STEPS_W-1:0] wraps_q, wraps_d;

  logic               gnt0, gnt1, accept;
  logic [1:0]         sel_mode;
  logic               sel_pre;
  logic [3:0]         sel_d;
  logic [STEPS_W-1:0] sel_steps;

  rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  assign req0_ready = (state_q == ST_IDLE) && gnt0;
  assign req1_ready = (state_q == ST_IDLE) && gnt1;
  assign accept     = req0_ready || req1_ready;

  assign sel_mode  = gnt1 ? req1_mode    : req0_mode;
  assign sel_pre   = gnt1 ? req1_preload : req0_preload;
  assign sel_d     = gnt1 ? req1_d       : req0_d;
  assign sel_steps = gnt1 ? req1_steps   : req0_steps;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mode_d       = mode_q;
    d_d          = d_q;
    steps_d      = steps_q;
    wcnt_d       = wcnt_q;
    id_d         = id_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    result_d     = result_q;
    wraps_d      = wraps_q;
    cnt_enable   = 1'b0;
    cnt_mode     = MODE_UP1;
    cnt_d        = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d         = gnt1;
          last_grant_d = gnt1;
          mode_d       = sel_mode;
          d_d          = sel_d;
          steps_d      = sel_steps;
          wcnt_d       = '0;
          if (sel_pre || (sel_mode == MODE_LOAD)) state_d = ST_LOAD;
          else if (sel_steps != '0)               state_d = ST_RUN;
          else                                    state_d = ST_CAPT;
        end
      end
      ST_LOAD: begin
        cnt_enable = 1'b1;
        cnt_mode   = MODE_LOAD;
        cnt_d      = d_q;
        if ((mode_q == MODE_LOAD) || (steps_q == '0)) state_d = ST_CAPT;
        else                                           state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_enable = 1'b1;
        cnt_mode   = mode_q;
        if (wrap_hit(mode_q, cnt_q)) wcnt_d = sat_inc(wcnt_q);
        steps_d = steps_q - 1'b1;
        if (steps_q == {{(STEPS_W-1){1'b0}}, 1'b1}) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        // Q is still valid here; the counter clears it on this same edge.
        done_d    = 1'b1;
        done_id_d = id_q;
        result_d  = cnt_q;
        wraps_d   = wcnt_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      mode_q       <= MODE_UP1;
      d_q          <= 4'd0;
      steps_q      <= '0;
      wcnt_q       <= '0;
      id_q         <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      result_q     <= 4'd0;
      wraps_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mode_q       <= mode_d;
      d_q          <= d_d;
      steps_q      <= steps_d;
      wcnt_q       <= wcnt_d;
      id_q         <= id_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      result_q     <= result_d;
      wraps_q      <= wraps_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign wraps   = wraps_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: models the counter slice, predicts each command's
// outcome arithmetically at accept time and checks it when done pulses.
module tb_counter_sched;

  localparam int STEPS_W = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic               req0_ready, req1_ready;
  logic [1:0]         req0_mode = '0, req1_mode = '0;
  logic               req0_preload = 1'b0, req1_preload = 1'b0;
  logic [3:0]         req0_d = '0, req1_d = '0;
  logic [STEPS_W-1:0] req0_steps = '0, req1_steps = '0;
  logic               cnt_enable;
  logic [1:0]         cnt_mode;
  logic [3:0]         cnt_d;
  logic [3:0]         cnt_q = 4'd0;
  logic               busy, done, done_id;
  logic [3:0]         result;
  logic [STEPS_W-1:0] wraps;

  counter_sched #(.STEPS_W(STEPS_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_preload(req0_preload), .req0_d(req0_d), .req0_steps(req0_steps),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_preload(req1_preload), .req1_d(req1_d), .req1_steps(req1_steps),
    .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_d(cnt_d), .cnt_q(cnt_q),
    .busy(busy), .done(done), .done_id(done_id), .result(result), .wraps(wraps)
  );

  always #5 clk = ~clk;

  // Counter slice: clears when disabled, otherwise loads or steps.
  always @(posedge clk) begin
    if (!cnt_enable) cnt_q <= 4'd0;
    else case (cnt_mode)
      2'd0: cnt_q <= cnt_q + 4'd1;
      2'd1: cnt_q <= cnt_q - 4'd1;
      2'd2: cnt_q <= cnt_q - 4'd3;
      default: cnt_q <= cnt_d;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int res;
    int wr;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   acc_ids[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: Q starts at 0 (idle clears it) or at d; each step adds delta and
  // counts a wrap whenever the unbounded result leaves 0..15.
  function automatic exp_t model(input int id, input int mode, input int pre,
                                 input int d, input int steps, input int acc_edge);
    exp_t e;
    int q, w, lat, delta, nq;
    q = 0; w = 0; lat = 1;
    delta = (mode == 0) ? 1 : (mode == 1) ? -1 : -3;
    if (pre != 0 || mode == 3) begin
      q = d;
      lat = lat + 1;
    end
    if (mode != 3) begin
      for (int i = 0; i < steps; i++) begin
        nq = q + delta;
        if (nq < 0 || nq > 15) w = w + 1;
        q = (nq + 16) % 16;
      end
      lat = lat + steps;
    end
    if (w > 255) w = 255;
    e.id = id; e.res = q; e.wr = w; e.due = acc_edge + lat;
    return e;
  endfunction

  // Accept watcher: push the prediction for every handshake about to complete.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_valid && req0_ready) begin
        sb_q.push_back(model(0, int'(req0_mode), int'(req0_preload), int'(req0_d),
                             int'(req0_steps), cyc + 1));
        acc_ids.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back(model(1, int'(req1_mode), int'(req1_preload), int'(req1_d),
                             int'(req1_steps), cyc + 1));
        acc_ids.push_back(1);
      end
    end
  end

  // Monitor: compare on every done pulse, plus per-cycle protocol checks.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("ready_exclusive", int'(req0_ready && req1_ready), 0);
      if (!busy) chk("idle_pins", int'({cnt_enable, cnt_mode, cnt_d}), 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_id", int'(done_id), e.id);
          chk("result", int'(result), e.res);
          chk("wraps", int'(wraps), e.wr);
          chk("latency_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic set_req(input int id, input int mode, input int pre,
                         input int d, input int steps);
    if (id == 0) begin
      req0_mode = 2'(mode); req0_preload = 1'(pre); req0_d = 4'(d);
      req0_steps = STEPS_W'(steps); req0_valid = 1'b1;
    end else begin
      req1_mode = 2'(mode); req1_preload = 1'(pre); req1_d = 4'(d);
      req1_steps = STEPS_W'(steps); req1_valid = 1'b1;
    end
  endtask

  // Hold valids until each is accepted; drop a valid just after its edge.
  task automatic run_pending();
    int  n;
    logic a0, a1;
    n = 0;
    while ((req0_valid || req1_valid) && n < 3000) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      n++;
    end
    if (n >= 3000) begin
      chk("accept_timeout", 1, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_enable", int'(cnt_enable), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_outputs", int'({done_id, result, wraps}), 0);
  endtask

  initial begin
    int r, id;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs();

    // Both valid from reset: req0, then req1; again both: req0 next.
    @(posedge clk); #1;
    acc_ids.delete();
    set_req(0, 0, 0, 0, 18);
    set_req(1, 2, 1, 5, 3);
    run_pending();
    wait_idle();
    chk("first_grant", acc_ids.size() > 0 ? acc_ids[0] : -1, 0);
    chk("second_grant", acc_ids.size() > 1 ? acc_ids[1] : -1, 1);
    chk("plan_down3_result", int'(result), 12);
    chk("plan_down3_wraps", int'(wraps), 1);
    set_req(0, 1, 0, 0, 2);
    set_req(1, 0, 0, 0, 2);
    run_pending();
    wait_idle();
    chk("alternate_grant", acc_ids.size() > 2 ? acc_ids[2] : -1, 0);

    set_req(0, 0, 0, 0, 18);
    run_pending();
    wait_idle();
    chk("plan_up1_result", int'(result), 2);
    chk("plan_up1_wraps", int'(wraps), 1);

    set_req(0, 1, 0, 0, 0);
    run_pending();
    wait_idle();
    chk("zero_steps_result", int'(result), 0);
    set_req(0, 3, 0, 9, 77);
    run_pending();
    wait_idle();
    chk("load_only_result", int'(result), 9);
    chk("load_only_wraps", int'(wraps), 0);

    set_req(0, 1, 0, 0, 255);
    run_pending();
    wait_idle();
    chk("long_dn1_wraps", int'(wraps), 16);
    chk("long_dn1_result", int'(result), 1);

    // Reset during a long command: abort with no done.
    set_req(1, 0, 0, 0, 100);
    run_pending();
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    check_reset_outputs();
    repeat (20) @(posedge clk);
    #1;
    acc_ids.delete();
    set_req(1, 2, 0, 0, 4);
    set_req(0, 0, 1, 14, 3);
    run_pending();
    wait_idle();
    chk("post_reset_grant", acc_ids.size() > 0 ? acc_ids[0] : -1, 0);

    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 3));
      id = int'($urandom_range(0, 1));
      if (r == 3) begin
        set_req(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 40)));
        set_req(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 40)));
      end else begin
        set_req(id, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 40)));
      end
      run_pending();
      if (r == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
